// File: rtl/fetch_seq_pkg.sv
// Shared definitions for the fetch sequencer: data width, FSM state encodings
// and the retired-counter step.
package fetch_seq_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4,
    ST_FAULT  = 3'd5
  } state_t;

  // Retired count is a plain 16-bit wrap-around counter.
  function automatic logic [15:0] retired_next(input logic [15:0] cnt);
    return cnt + 16'd1;
  endfunction

endpackage

// File: rtl/fetch_seq_if.sv
// Instruction-memory fetch bus between the sequencer (master) and the
// instruction memory (slave).
interface fetch_seq_if;
  import fetch_seq_pkg::*;

  logic              imem_req;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_rdata;

  modport master (output imem_req, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, output imem_ack, output imem_rdata);

endinterface

// File: rtl/fetch_seq.sv
// Fetch/decode/execute sequencer with fetch timeout and retired counter.
// Optional interrupt take-over is enabled by defining FETCH_SEQ_IRQ_EN.
module fetch_seq
  import fetch_seq_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              run,
  fetch_seq_if.master       imem,
  output logic [DATA_W-1:0] ir,
  output logic              ir_valid,
  input  logic              exec_done,
  input  logic              br_taken,
  input  logic              halt,
  output logic              pc_en,
  output logic              pc_bre,
  output logic              fault,
  output logic [15:0]       retired,
  output logic [2:0]        state
`ifdef FETCH_SEQ_IRQ_EN
  ,
  input  logic              irq,
  output logic              irq_take
`endif
);

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q;
  state_t      state_d;
  logic [7:0]  wait_cnt;
  logic [15:0] retired_cnt;
  logic        ack_hit;

  assign ack_hit = (state_q == ST_FETCH) && imem.imem_ack;
  assign fault   = (state_q == ST_FAULT);
  assign retired = retired_cnt;
  assign state   = state_q;

  // PC strobes are gated by rst so a reset during EXEC never leaks a pc_en pulse.
  always_comb begin
    state_d       = state_q;
    imem.imem_req = 1'b0;
    ir_valid      = 1'b0;
    pc_en         = 1'b0;
    pc_bre        = 1'b0;
`ifdef FETCH_SEQ_IRQ_EN
    irq_take      = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        imem.imem_req = 1'b1;
        if (imem.imem_ack)
          state_d = ST_DECODE;
        else if (wait_cnt == WAIT_LAST)
          state_d = ST_FAULT;
      end
      ST_DECODE: begin
        ir_valid = 1'b1;
        state_d  = ST_EXEC;
      end
      ST_EXEC: begin
        if (exec_done) begin
          pc_en  = !rst;
          pc_bre = br_taken && !rst;
          if (halt)
            state_d = ST_HALT;
          else
            state_d = ST_FETCH;
`ifdef FETCH_SEQ_IRQ_EN
          // Interrupt: datapath substitutes the vector, so no branch select.
          if (!halt && irq) begin
            pc_bre   = 1'b0;
            irq_take = !rst;
          end
`endif
        end
      end
      ST_HALT: begin
        if (run) state_d = ST_FETCH;
`ifdef FETCH_SEQ_IRQ_EN
        if (irq) begin
          state_d  = ST_FETCH;
          irq_take = !rst;
        end
`endif
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Wait counter restarts from zero on every entry into FETCH.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wait_cnt    <= '0;
      ir          <= '0;
      retired_cnt <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == ST_FETCH) && (state_d == ST_FETCH))
        wait_cnt <= wait_cnt + 8'd1;
      else
        wait_cnt <= '0;
      if (ack_hit)
        ir <= imem.imem_rdata;
      if (pc_en)
        retired_cnt <= retired_next(retired_cnt);
    end
  end

endmodule

// File: doc/fetch_seq.md
FETCH_SEQ -- requirements
Module: fetch_seq

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, max cycles waiting for imem_ack before fault (range 2..255).
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port run  input  1  start/resume request (level).
REQ-005 SHALL have port imem_req  output  1  instruction fetch request at current PC.
REQ-006 SHALL have port imem_ack  input  1  instruction data valid this cycle.
REQ-007 SHALL have port imem_rdata  input  DATA_W  fetched instruction word.
REQ-008 SHALL have port ir  output  DATA_W  instruction register.
REQ-009 SHALL have port ir_valid  output  1  one-cycle decode strobe.
REQ-010 SHALL have port exec_done  input  1  execute stage complete.
REQ-011 SHALL have port br_taken  input  1  branch taken, qualified by exec_done.
REQ-012 SHALL have port halt  input  1  halt instruction, qualified by exec_done.
REQ-013 SHALL have port pc_en  output  1  PC update enable (PC holds when 0).
REQ-014 SHALL have port pc_bre  output  1  branch enable to PC, valid only with pc_en.
REQ-015 SHALL have port fault  output  1  sticky fetch-timeout flag.
REQ-016 SHALL have port retired  output  16  retired-instruction count.
REQ-017 SHALL have port state  output  3  current FSM state encoding, debug.

Function
REQ-018 SHALL implement states IDLE, FETCH, DECODE, EXEC, HALT, FAULT.
REQ-019 IDLE: SHALL go to FETCH on the cycle after run=1; otherwise stay.
REQ-020 FETCH: SHALL assert imem_req=1; on imem_ack=1 SHALL load ir<=imem_rdata and go to DECODE next cycle.
REQ-021 FETCH: SHALL count wait cycles from 0; if TIMEOUT cycles elapse with no ack, SHALL go to FAULT; counter SHALL clear on entry to FETCH.
REQ-022 An ack arriving in the same cycle the count reaches TIMEOUT SHALL win (go to DECODE, no fault).
REQ-023 DECODE: SHALL assert ir_valid=1 for exactly one cycle, then go to EXEC.
REQ-024 EXEC: SHALL wait for exec_done; on exec_done SHALL assert pc_en=1 and pc_bre=br_taken for that single cycle and increment retired (wrap 0xFFFF->0x0000).
REQ-025 EXEC with exec_done and halt=1: SHALL go to HALT; otherwise SHALL go to FETCH.
REQ-026 halt and br_taken both 1: branch SHALL still be applied (pc_en=1, pc_bre=1), then HALT.
REQ-027 HALT: SHALL go to FETCH when run=1; pc_en SHALL stay 0.
REQ-028 FAULT: SHALL hold fault=1, imem_req=0, pc_en=0 until rst.
REQ-029 pc_en, pc_bre, ir_valid, imem_req SHALL be 0 in every state not listed for them; exec_done/br_taken/halt SHALL be ignored outside EXEC.
REQ-030 imem_ack outside FETCH SHALL be ignored; ir SHALL only change on accepted ack.

Reset
REQ-031 rst=1 SHALL, at the next edge, force state=IDLE, ir=0, ir_valid=0, imem_req=0, pc_en=0, pc_bre=0, fault=0, retired=0, wait counter=0, irq_take=0.
REQ-032 rst asserted mid-fetch or mid-exec SHALL abandon the operation with no pc_en pulse.

Configuration
REQ-033 Macro FETCH_SEQ_IRQ_EN SHALL, when defined, add ports irq (input 1, level) and irq_take (output 1, one-cycle pulse).
REQ-034 With FETCH_SEQ_IRQ_EN: on exec_done with irq=1 and halt=0 SHALL assert pc_en=1, pc_bre=0, irq_take=1 (datapath substitutes vector), go to FETCH; irq=1 in HALT SHALL act as run and pulse irq_take on exit.
REQ-035 Without FETCH_SEQ_IRQ_EN: no irq ports; behaviour exactly REQ-018..REQ-032.

Structure
REQ-036 DATA_W and state encodings (3-bit constants) SHALL live in the shared def.v definitions header.
REQ-037 The FSM and counters SHALL be in one module; no sub-module required; it SHALL drive the existing PC block via pc_en/pc_bre.

Verification
REQ-038 Reset then run=1, ack 2 cycles after imem_req, exec_done after 3 cycles -> ir=imem_rdata, one ir_valid pulse, pc_en pulse with pc_bre=0, retired=1.
REQ-039 exec_done with br_taken=1 -> pc_en=1, pc_bre=1 same cycle; next state FETCH.
REQ-040 exec_done with halt=1 -> state HALT, no imem_req until run=1, then FETCH.
REQ-041 TIMEOUT=4, no ack -> fault=1 after 4 FETCH cycles, sticky; ack on 4th cycle -> DECODE, fault=0.
REQ-042 retired preset via 65535 completions -> next completion gives retired=0.
REQ-043 With FETCH_SEQ_IRQ_EN, irq=1 at exec_done -> irq_take=1, pc_en=1, pc_bre=0 one cycle; rst mid-EXEC -> IDLE, no pc_en.
